// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer: DEPTH-entry elastic FIFO with flush and
// occupancy, or a purely combinational pass-through when BYPASS is set.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter bit BYPASS = 1'b0,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]  count
);

   generate
      if (BYPASS) begin : g_bypass
         assign s_ready = m_ready;
         assign m_valid = s_valid;
         assign m_data  = s_data;
         assign count   = '0;

         // Clock, reset and flush have no function in pass-through mode.
         logic unused_bypass;
         assign unused_bypass = &{1'b0, clk, rst, flush};
      end else begin : g_buf
         localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
         localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
         localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

         logic [DATA_W-1:0] mem [DEPTH];
         logic [PTR_W-1:0]  wr_ptr;
         logic [PTR_W-1:0]  rd_ptr;
         logic [CNT_W-1:0]  cnt_q;
         logic              push;
         logic              pop;

         function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == LAST) ? '0 : p + 1'b1;
         endfunction

         // Ready is a function of occupancy only, so m_ready never reaches s_ready.
         assign s_ready = (cnt_q != FULL);
         assign m_valid = (cnt_q != '0);
         assign m_data  = mem[rd_ptr];
         assign count   = cnt_q;
         assign push    = s_valid & s_ready;
         assign pop     = m_valid & m_ready;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt_q  <= '0;
            end else if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt_q  <= '0;
            end else begin
               if (push) wr_ptr <= ptr_inc(wr_ptr);
               if (pop)  rd_ptr <= ptr_inc(rd_ptr);
               if (push && !pop)      cnt_q <= cnt_q + 1'b1;
               else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            end
         end

         // Entries are cleared only by reset; flush just rewinds the pointers.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (push && !flush) begin
               mem[wr_ptr] <= s_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH 1..4 buffers plus a bypass instance, checked
// against per-instance queue models under directed and random traffic.
module tb_pipe_stage_buf;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] s_data = '0;

   logic [4:1]    s_ready_d;
   logic [4:1]    m_valid_d;
   logic [DW-1:0] m_data_d [1:4];
   logic [7:0]    cnt_d [1:4];

   logic          byp_s_ready;
   logic          byp_m_valid;
   logic [DW-1:0] byp_m_data;
   logic [1:0]    byp_count;

   int n_cmp = 0;
   int n_err = 0;

   typedef logic [DW-1:0] word_q_t [$];
   word_q_t mq [1:4];

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 4; g++) begin : g_dut
      localparam int CW = $clog2(g + 1);
      logic [CW-1:0] cnt;
      pipe_stage_buf #(.DATA_W(DW), .DEPTH(g), .BYPASS(1'b0)) u_dut (
         .clk(clk), .rst(rst), .flush(flush),
         .s_valid(s_valid), .s_ready(s_ready_d[g]), .s_data(s_data),
         .m_valid(m_valid_d[g]), .m_ready(m_ready), .m_data(m_data_d[g]),
         .count(cnt)
      );
      assign cnt_d[g] = 8'(cnt);
   end

   pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(byp_s_ready), .s_data(s_data),
      .m_valid(byp_m_valid), .m_ready(m_ready), .m_data(byp_m_data),
      .count(byp_count)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int g = 1; g <= 4; g++) mq[g].delete();
   endtask

   task automatic check_all(input string tag);
      for (int g = 1; g <= 4; g++) begin
         int n = mq[g].size();
         check_val($sformatf("%s_d%0d_count", tag, g), 64'(cnt_d[g]), 64'(n));
         check_val($sformatf("%s_d%0d_s_ready", tag, g), 64'(s_ready_d[g]), 64'(n < g));
         check_val($sformatf("%s_d%0d_m_valid", tag, g), 64'(m_valid_d[g]), 64'(n > 0));
         if (n > 0)
            check_val($sformatf("%s_d%0d_m_data", tag, g), 64'(m_data_d[g]), 64'(mq[g][0]));
      end
      check_val({tag, "_byp_m_valid"}, 64'(byp_m_valid), 64'(s_valid));
      check_val({tag, "_byp_s_ready"}, 64'(byp_s_ready), 64'(m_ready));
      check_val({tag, "_byp_m_data"}, 64'(byp_m_data), 64'(s_data));
      check_val({tag, "_byp_count"}, 64'(byp_count), 64'd0);
   endtask

   // Applies the transfer rules for the inputs currently on the bus.
   task automatic model_step();
      if (!rst) return;
      for (int g = 1; g <= 4; g++) begin
         if (flush) begin
            mq[g].delete();
         end else begin
            int  n = mq[g].size();
            bit  do_push = s_valid && (n < g);
            bit  do_pop  = (n > 0) && m_ready;
            if (do_pop)  void'(mq[g].pop_front());
            if (do_push) mq[g].push_back(s_data);
         end
      end
   endtask

   task automatic cycle(input string tag);
      @(negedge clk);
      check_all(tag);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
      s_valid = v;
      s_data  = d;
      m_ready = r;
      flush   = f;
   endtask

   initial begin
      // Reset and idle
      clear_model();
      #1;
      check_val("rst_s_ready", 64'(s_ready_d[2]), 64'd1);
      check_val("rst_m_valid", 64'(m_valid_d[2]), 64'd0);
      check_val("rst_m_data", 64'(m_data_d[2]), 64'd0);
      check_val("rst_count", 64'(cnt_d[2]), 64'd0);
      cycle("rst_hold");
      cycle("rst_hold");
      rst = 1'b1;
      for (int g = 1; g <= 4; g++)
         check_val($sformatf("post_rst_d%0d_m_data", g), 64'(m_data_d[g]), 64'd0);
      cycle("post_rst");

      // Latency and order
      drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
      cycle("lat_push");
      drive(1'b0, '0, 1'b1, 1'b0);
      check_val("lat_m_valid", 64'(m_valid_d[2]), 64'd1);
      check_val("lat_m_data", 64'(m_data_d[2]), 64'hA5A5_0001);
      cycle("lat_pop");
      check_val("lat_count_after_pop", 64'(cnt_d[2]), 64'd0);

      // Fill and backpressure on the depth-3 buffer
      drive(1'b0, '0, 1'b0, 1'b1);
      cycle("fill_flush");
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, DW'(k * 32'h11), 1'b0, 1'b0);
         cycle("fill_push");
      end
      check_val("fill_d3_count", 64'(cnt_d[3]), 64'd3);
      check_val("fill_d3_s_ready", 64'(s_ready_d[3]), 64'd0);
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         check_val($sformatf("drain_d3_m_data_%0d", k), 64'(m_data_d[3]), 64'(k * 32'h11));
         cycle("drain");
         check_val($sformatf("drain_d3_s_ready_%0d", k), 64'(s_ready_d[3]), 64'd1);
      end
      check_val("drain_d3_count", 64'(cnt_d[3]), 64'd0);

      // Full throughput with pointer wrap
      for (int k = 1; k <= 11; k++) begin
         drive(k <= 10, DW'(k), 1'b1, 1'b0);
         if (k >= 2) begin
            check_val($sformatf("tput_d3_m_valid_%0d", k), 64'(m_valid_d[3]), 64'd1);
            check_val($sformatf("tput_d3_m_data_%0d", k), 64'(m_data_d[3]), 64'(k - 1));
         end
         cycle("tput");
      end
      check_val("tput_d3_count", 64'(cnt_d[3]), 64'd0);

      // Flush discards stored and simultaneous traffic
      drive(1'b0, '0, 1'b0, 1'b1);
      cycle("fl_pre");
      drive(1'b1, 32'hAA, 1'b0, 1'b0);
      cycle("fl_fill");
      drive(1'b1, 32'hBB, 1'b0, 1'b0);
      cycle("fl_fill");
      check_val("fl_d4_count_before", 64'(cnt_d[4]), 64'd2);
      drive(1'b1, 32'h99, 1'b1, 1'b1);
      cycle("fl_flush");
      drive(1'b0, '0, 1'b1, 1'b0);
      check_val("fl_d4_count", 64'(cnt_d[4]), 64'd0);
      check_val("fl_d4_m_valid", 64'(m_valid_d[4]), 64'd0);
      check_val("fl_d4_s_ready", 64'(s_ready_d[4]), 64'd1);
      for (int k = 0; k < 3; k++) begin
         cycle("fl_after");
         check_val("fl_d4_no_99", 64'(m_valid_d[4]), 64'd0);
      end

      // Bypass pass-through
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      #1;
      check_val("byp_m_valid", 64'(byp_m_valid), 64'd1);
      check_val("byp_m_data", 64'(byp_m_data), 64'hDEAD_BEEF);
      check_val("byp_s_ready_0", 64'(byp_s_ready), 64'd0);
      m_ready = 1'b1;
      #1;
      check_val("byp_s_ready_1", 64'(byp_s_ready), 64'd1);
      check_val("byp_count", 64'(byp_count), 64'd0);
      cycle("byp");

      // Asynchronous reset while full
      drive(1'b1, 32'h5, 1'b0, 1'b0);
      cycle("ar_fill");
      drive(1'b1, 32'h6, 1'b0, 1'b0);
      cycle("ar_fill");
      check_val("ar_d2_count_before", 64'(cnt_d[2]), 64'd2);
      #2;
      rst = 1'b0;
      #1;
      check_val("ar_d2_count", 64'(cnt_d[2]), 64'd0);
      check_val("ar_d2_m_valid", 64'(m_valid_d[2]), 64'd0);
      check_val("ar_d2_s_ready", 64'(s_ready_d[2]), 64'd1);
      check_val("ar_d2_m_data", 64'(m_data_d[2]), 64'd0);
      clear_model();
      cycle("ar_hold");
      rst = 1'b1;

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 31) == 0);
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 255) == 0) begin
            rst = 1'b0;
            clear_model();
         end
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised valid/ready pipeline-stage buffer that registers a packed payload between two pipeline stages (e.g. M→W). It generalises the single-cycle pass-through stage register into a DEPTH-entry elastic buffer with flush and occupancy reporting. A BYPASS mode preserves the combinational single-cycle behaviour, so a stage can be switched between single-cycle and pipelined operation by parameter alone.

## Interface
- DATA_W, 32: payload width in bits (all stage signals packed by the instantiating stage); ≥1.
- DEPTH, 2: number of buffer entries; ≥1; need not be a power of two.
- BYPASS, 0: 1 = combinational pass-through, no storage; 0 = registered buffer.
- CNT_W, $clog2(DEPTH+1): derived, not overridden; width of `count`.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous; discards all buffered entries.
- s_valid  in  1  upstream has a payload.
- s_ready  out  1  buffer accepts a payload this cycle.
- s_data  in  DATA_W  upstream payload.
- m_valid  out  1  buffer presents a payload.
- m_ready  in  1  downstream accepts the payload.
- m_data  out  DATA_W  payload at head of buffer.
- count  out  CNT_W  number of valid entries (0..DEPTH).

## Operation
- Push = s_valid & s_ready; pop = m_valid & m_ready; both sampled at the rising edge.
- BYPASS=0:
  - Storage: DEPTH×DATA_W array, write pointer, read pointer, entry counter.
  - s_ready = (count != DEPTH); depends only on state, with no combinational path from m_ready.
  - m_valid = (count != 0); m_data = entry at read pointer.
  - On push: write s_data at the write pointer and advance it. On pop: advance the read pointer. Pointers wrap from DEPTH-1 to 0.
  - count: +1 on push only, −1 on pop only, unchanged on push+pop.
  - Full (count==DEPTH): s_ready=0, so no push occurs even if a pop happens in the same cycle. The freed slot becomes visible the next cycle.
  - Empty (count==0): m_valid=0. A payload pushed in cycle N is not forwarded in cycle N.
  - flush=1: next state is count=0 and both pointers 0. Any push or pop in the same cycle is discarded. Array contents are not cleared.
  - Entries leave in strict FIFO order and are never duplicated or dropped except by flush or reset.
- BYPASS=1:
  - s_ready=m_ready, m_valid=s_valid, m_data=s_data, count=0.
  - flush is ignored and no registers are instantiated.
  - clk and rst are unused.

## Timing
- Reset (rst=0, async): count=0, pointers=0, all array entries=0. Outputs during reset: s_ready=1, m_valid=0, m_data=0, count=0. The same values hold in the first cycle after release.
- Reset asserted mid-operation: all entries are lost immediately; outputs take their reset values without waiting for a clock edge.
- Latency (BYPASS=0): a payload accepted at edge N is presented with m_valid=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: DEPTH≥2 sustains 1 transfer/cycle with continuous s_valid and m_ready. DEPTH=1 sustains 1 transfer every 2 cycles.
- Flush at edge N: m_valid=0 and s_ready=1 in the cycle after edge N.
- count is registered and changes only at clock edges.
- BYPASS=1 latency is 0 cycles, purely combinational.

## Test plan
- Reset/idle: hold rst=0, then release with DEPTH=2 → s_ready=1, m_valid=0, m_data=0, count=0. Assert rst=0 while count=2 → count=0 and m_valid=0 without a clock edge.
- Latency/order: DEPTH=2, m_ready=1, push 0xA5A5_0001 at edge 0 → m_valid=1 and m_data=0xA5A5_0001 after edge 0; pop at edge 1 → count=0.
- Fill/backpressure: DEPTH=3, m_ready=0, push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count=3, s_ready=0, 0x44 not accepted. Then m_ready=1 → outputs 0x11, 0x22, 0x33 in order, with s_ready=1 after the first pop.
- Full throughput and wrap: DEPTH=3, s_valid=m_ready=1 for 10 cycles with incrementing data 1..10 → data 1..10 arrive in order, one per cycle after a 1-cycle latency, with pointers wrapping 3 times.
- Flush: DEPTH=4 holding 2 entries, flush=1 together with s_valid=1 (data 0x99) and m_ready=1 → next cycle count=0, m_valid=0, and 0x99 is never output.
- Bypass: BYPASS=1, s_valid=1, s_data=0xDEAD_BEEF, m_ready=0 then 1 → m_valid=1 and m_data=0xDEAD_BEEF in the same cycle; s_ready follows m_ready (0, then 1); count stays 0.
